sprite_lookup: RTL and testbench
================================

SPRITE_LOOKUP -- requirements
Module: sprite_lookup

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 32: number of sprite registers; power of two, 2..64.
REQ-002 SHALL have parameter SPRITE_SIZE, default 20: sprite edge length in pixels.
REQ-003 SHALL have parameter BG_CODE, default 32'h00000001: reply meaning "pixel is background".
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 wr_en  in  1  sprite register write strobe.
REQ-007 wr_addr  in  log2(NUM_SPRITES)  sprite register index.
REQ-008 wr_data  in  32  sprite word: [31] enable, [30:22] x, [21:13] y, [12:4] memory offset, [3:0] reserved.
REQ-009 check_req  in  1  single-cycle lookup request.
REQ-010 check_value  in  18  pixel coordinate: [17:9] x, [8:0] y; sampled when check_req=1.
REQ-011 data_reg  out  32  lookup result: matching sprite word or BG_CODE.
REQ-012 data_valid  out  1  one-cycle pulse when data_reg is updated.
REQ-013 busy  out  1  high while a lookup is in progress.

Function
REQ-014 SHALL use a three-state FSM: IDLE, SCAN, DONE.
REQ-015 IDLE: check_req=1 SHALL latch check_value, clear the index to 0, set busy=1 and go to SCAN.
REQ-016 SCAN: one sprite register SHALL be compared per cycle, in ascending index order.
REQ-017 Hit condition SHALL be: enable=1, x <= px < x+SPRITE_SIZE, and y <= py < y+SPRITE_SIZE.
REQ-018 Hit comparisons SHALL use 10-bit unsigned sums so that x+SPRITE_SIZE never wraps.
REQ-019 On the first hit, the FSM SHALL capture the sprite word with bits [3:0] forced to 0 and go to DONE.
REQ-020 If index NUM_SPRITES-1 misses, the FSM SHALL capture BG_CODE and go to DONE.
REQ-021 DONE SHALL drive the captured word on data_reg, pulse data_valid for one cycle, clear busy and return to IDLE.
REQ-022 Latency from check_req to data_valid SHALL be k+2 cycles for a hit at index k, and NUM_SPRITES+1 cycles for background.
REQ-023 data_reg SHALL hold its value until the next data_valid.
REQ-024 check_req while busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-025 A write to any entry SHALL always succeed, including during SCAN.
REQ-026 A write to the entry compared in the same cycle SHALL not affect that comparison, which uses the old contents.
REQ-027 A write to an entry already scanned SHALL not re-trigger the lookup.
REQ-028 Overlapping sprites: the lowest index SHALL win.

Reset
REQ-029 reset=0 SHALL force IDLE immediately, including mid-scan; any in-flight lookup SHALL be abandoned with no data_valid.
REQ-030 Reset values SHALL be: data_reg=BG_CODE, data_valid=0, busy=0, all sprite registers 0 (disabled), latched coordinate 0, index 0.

Configuration
REQ-031 Macro LOOKUP_HIT_CNT_EN defined SHALL add output hit_count[15:0].
REQ-032 hit_count SHALL increment on each data_valid carrying a sprite hit, wrap from 16'hFFFF to 0, and reset to 0.
REQ-033 Macro undefined SHALL leave no hit_count port and no counter logic; all other behaviour is identical.

Structure
REQ-034 Shared package console_pkg SHALL hold the sprite word field positions, BG_CODE default, SPRITE_SIZE default, check_value field positions and FSM state encoding.
REQ-035 The single sub-module sprite_hit_cmp SHALL take one sprite word and the latched coordinate, and output a 1-bit hit.
REQ-036 sprite_hit_cmp SHALL be purely combinational and instanced once, fed by an index-selected mux.

Verification
REQ-037 Empty table: after reset, check_req with x=100,y=50 -> data_valid after 33 cycles, data_reg=32'h00000001.
REQ-038 Single hit: sprite 5 = {en=1,x=100,y=50,off=7}; check (119,69) -> data_reg=sprite word with [3:0]=0, data_valid 7 cycles after check_req.
REQ-039 Boundary: same sprite; checks (120,50), (100,70) and (99,50) -> each returns BG_CODE; check (100,50) -> hit.
REQ-040 Priority and wrap: sprites 2 and 9 both cover (470,300), sprite 9 at x=470 -> returns sprite 2; delete sprite 2 -> returns sprite 9, with no wrap false-hit at (5,300).
REQ-041 Ignored request and mid-scan write: pulse check_req during SCAN -> only one data_valid; write sprite 0 after it is scanned -> result unchanged.
REQ-042 Reset mid-scan: assert reset at cycle 10 of a scan -> no data_valid, busy=0, data_reg=BG_CODE; with LOOKUP_HIT_CNT_EN, 3 hits -> hit_count=3, then reset -> 0.

Source files
------------

// File: rtl/console_pkg.sv
// console_pkg -- shared definitions for the sprite lookup block.
//   Sprite word layout : [31] enable, [30:22] x, [21:13] y, [12:4] memory offset, [3:0] reserved
//   check_value layout : [17:9] x, [8:0] y
//   Also holds the default sprite edge length, the background reply code and
//   the lookup FSM state encoding, plus field-extraction helpers.
package console_pkg;

    localparam int COORD_W     = 9;

    localparam int SPR_EN_BIT  = 31;
    localparam int SPR_X_MSB   = 30;
    localparam int SPR_X_LSB   = 22;
    localparam int SPR_Y_MSB   = 21;
    localparam int SPR_Y_LSB   = 13;
    localparam int SPR_OFF_MSB = 12;
    localparam int SPR_OFF_LSB = 4;
    localparam int SPR_RSV_MSB = 3;

    localparam int CHK_X_MSB   = 17;
    localparam int CHK_X_LSB   = 9;
    localparam int CHK_Y_MSB   = 8;
    localparam int CHK_Y_LSB   = 0;

    localparam int          SPRITE_SIZE_DEF = 20;
    localparam logic [31:0] BG_CODE_DEF     = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } lookup_state_t;

    function automatic logic [COORD_W-1:0] spr_x(input logic [31:0] w);
        return w[SPR_X_MSB:SPR_X_LSB];
    endfunction

    function automatic logic [COORD_W-1:0] spr_y(input logic [31:0] w);
        return w[SPR_Y_MSB:SPR_Y_LSB];
    endfunction

endpackage

// File: rtl/sprite_lookup_hit_cmp.sv
// sprite_hit_cmp -- combinational test of one sprite word against a pixel.
//   sprite_word in 32 : sprite register contents
//   px, py      in 9  : latched pixel coordinate
//   hit         out 1 : sprite enabled and pixel inside its square
module sprite_hit_cmp
    import console_pkg::*;
#(
    parameter int SPRITE_SIZE = SPRITE_SIZE_DEF
) (
    input  logic [31:0]        sprite_word,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               hit
);

    localparam logic [COORD_W:0] SIZE10 = (COORD_W+1)'(SPRITE_SIZE);

    logic [COORD_W:0] sx, sy, px10, py10;
    logic             in_x, in_y;

    // One extra bit keeps x+SPRITE_SIZE from wrapping past the screen edge.
    assign sx   = {1'b0, spr_x(sprite_word)};
    assign sy   = {1'b0, spr_y(sprite_word)};
    assign px10 = {1'b0, px};
    assign py10 = {1'b0, py};

    assign in_x = (px10 >= sx) && (px10 < (sx + SIZE10));
    assign in_y = (py10 >= sy) && (py10 < (sy + SIZE10));
    assign hit  = sprite_word[SPR_EN_BIT] && in_x && in_y;

endmodule

// File: rtl/sprite_lookup.sv
// sprite_lookup -- sprite register file plus a sequential first-hit search.
//   clk, reset (async, active-low)
//   wr_en/wr_addr/wr_data : sprite register write port (always accepted)
//   check_req/check_value : lookup request, coordinate {x[17:9], y[8:0]}
//   data_reg              : matching sprite word ([3:0] cleared) or BG_CODE
//   data_valid            : one-cycle pulse when data_reg updates
//   busy                  : lookup in progress
//   hit_count             : present only when LOOKUP_HIT_CNT_EN is defined
//
// state   | meaning
// IDLE    | waiting for check_req
// SCAN    | comparing sprite[idx] against the latched coordinate
// DONE    | publishing the captured word, then back to IDLE
module sprite_lookup
    import console_pkg::*;
#(
    parameter int          NUM_SPRITES = 32,
    parameter int          SPRITE_SIZE = SPRITE_SIZE_DEF,
    parameter logic [31:0] BG_CODE     = BG_CODE_DEF,
    localparam int         IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             check_req,
    input  logic [17:0]      check_value,
    output logic [31:0]      data_reg,
    output logic             data_valid,
`ifdef LOOKUP_HIT_CNT_EN
    output logic [15:0]      hit_count,
`endif
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    logic [31:0]        sprites [NUM_SPRITES];
    lookup_state_t      state;
    logic [IDX_W-1:0]   idx;
    logic [COORD_W-1:0] px, py;
    logic [31:0]        cap_word;
    logic               cap_hit;
    logic [31:0]        sel_word;
    logic               hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) sprites[i] <= '0;
        end else if (wr_en) begin
            sprites[wr_addr] <= wr_data;
        end
    end

    // The compare sees the pre-write contents of the entry being written.
    assign sel_word = sprites[idx];

    sprite_hit_cmp #(.SPRITE_SIZE(SPRITE_SIZE)) u_cmp (
        .sprite_word (sel_word),
        .px          (px),
        .py          (py),
        .hit         (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            px         <= '0;
            py         <= '0;
            cap_word   <= BG_CODE;
            cap_hit    <= 1'b0;
            data_reg   <= BG_CODE;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (check_req) begin
                        px    <= check_value[CHK_X_MSB:CHK_X_LSB];
                        py    <= check_value[CHK_Y_MSB:CHK_Y_LSB];
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        cap_word <= {sel_word[31:SPR_RSV_MSB+1], 4'b0000};
                        cap_hit  <= 1'b1;
                        state    <= ST_DONE;
                    end else if (idx == LAST_IDX) begin
                        cap_word <= BG_CODE;
                        cap_hit  <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    data_reg   <= cap_word;
                    data_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LOOKUP_HIT_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hit_count <= '0;
        else if (state == ST_DONE && cap_hit)
            hit_count <= hit_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sprite_lookup.sv
module tb_sprite_lookup;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        check_req = 1'b0;
    logic [17:0] check_value = '0;
    logic [31:0] data_reg;
    logic        data_valid;
    logic        busy;
`ifdef LOOKUP_HIT_CNT_EN
    logic [15:0] hit_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] BG = 32'h0000_0001;

    sprite_lookup dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .check_req   (check_req),
        .check_value (check_value),
        .data_reg    (data_reg),
        .data_valid  (data_valid),
`ifdef LOOKUP_HIT_CNT_EN
        .hit_count   (hit_count),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input bit en, input int x, input int y, input int off);
        return {en, 9'(x), 9'(y), 9'(off), 4'hF};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start(input int x, input int y);
        @(negedge clk);
        check_req = 1'b1; check_value = {9'(x), 9'(y)};
        @(posedge clk);
        #1 check_req = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (data_valid) begin lat = i; break; end
        end
    endtask

    task automatic lookup(input string tag, input int x, input int y,
                          input logic [31:0] exp_word, input int exp_lat);
        int lat;
        start(x, y);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, data_reg, exp_word);
    endtask

    initial begin
        int lat, nvalid;
        logic [31:0] s5, s0, s2, s9, s12;
        s5  = mk(1, 100, 50, 7);
        s0  = mk(1, 95, 45, 3);
        s2  = mk(1, 460, 290, 1);
        s9  = mk(1, 470, 300, 2);
        s12 = mk(1, 500, 290, 4);

        #12;
        chk("rst_data_reg", data_reg, BG);
        chk("rst_valid", {31'b0, data_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk) reset = 1'b1;

        lookup("empty", 100, 50, BG, 33);

        wr(5, s5);
        lookup("hit5", 119, 69, 32'h9906_4070, 7);
        lookup("bnd_x120", 120, 50, BG, 33);
        lookup("bnd_y70", 100, 70, BG, 33);
        lookup("bnd_x99", 99, 50, BG, 33);
        lookup("bnd_org", 100, 50, 32'h9906_4070, 7);

        wr(2, s2);
        wr(9, s9);
        lookup("prio", 470, 300, {s2[31:4], 4'h0}, 4);
        wr(2, 32'h0);
        lookup("del2", 470, 300, {s9[31:4], 4'h0}, 11);
        lookup("nowrap9", 5, 300, BG, 33);
        wr(12, s12);
        lookup("nowrap12", 5, 300, BG, 33);
        lookup("hit12", 510, 300, {s12[31:4], 4'h0}, 14);

        // second request during SCAN must be dropped
        start(119, 69);
        @(posedge clk); #1;
        chk("busy_scan", {31'b0, busy}, 32'd1);
        @(negedge clk); check_req = 1'b1; check_value = {9'd470, 9'd300};
        @(negedge clk); check_req = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (data_valid) nvalid++;
        end
        chk("ign_count", 32'(nvalid), 32'd1);
        chk("ign_data", data_reg, 32'h9906_4070);

        // write sprite 0 after it has been scanned
        start(100, 50);
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = s0;
        @(posedge clk); #1 wr_en = 1'b0;
        wait_valid(lat);
        chk("late_wr_lat", 32'(lat + 3), 32'd7);
        chk("late_wr_data", data_reg, 32'h9906_4070);
        lookup("wr0_took", 100, 50, {s0[31:4], 4'h0}, 2);

        // delete sprite 0 in the same cycle it is compared
        start(100, 50);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0;
        @(posedge clk); #1 wr_en = 1'b0;
        wait_valid(lat);
        chk("same_wr_lat", 32'(lat + 1), 32'd2);
        chk("same_wr_data", data_reg, {s0[31:4], 4'h0});
        lookup("after_del0", 100, 50, 32'h9906_4070, 7);

        // fresh reset, hit counting, then reset mid-scan
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        lookup("clr_table", 100, 50, BG, 33);
        wr(5, s5);
        lookup("cnt_a", 100, 50, 32'h9906_4070, 7);
        lookup("cnt_b", 110, 60, 32'h9906_4070, 7);
        lookup("cnt_c", 119, 69, 32'h9906_4070, 7);
`ifdef LOOKUP_HIT_CNT_EN
        chk("hit_count3", {16'b0, hit_count}, 32'd3);
`endif
        start(0, 0);
        for (int i = 0; i < 9; i++) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #2;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_valid", {31'b0, data_valid}, 32'd0);
        chk("mid_rst_data", data_reg, BG);
`ifdef LOOKUP_HIT_CNT_EN
        chk("hit_count_rst", {16'b0, hit_count}, 32'd0);
`endif
        @(negedge clk) reset = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (data_valid) nvalid++;
        end
        chk("no_valid_after_rst", 32'(nvalid), 32'd0);
        lookup("table_cleared", 100, 50, BG, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
